display_arbiter: RTL and testbench
==================================

Name: display_arbiter

Overview:
- Shares the single 4-digit hex display datapath (16-bit value into the seven-segment scanner) between up to N_SRC requesters, e.g. CPU data bus, program counter and debug registers.
- Time-slices the display round-robin among active requesters, holding each for DWELL clock cycles.
- Drives the registered 16-bit value plus a one-hot source tag on the decimal points.
- Sits between the CPU/debug sources and the hex display driver, clocked by the divided CPU clock.

Parameters:
- N_SRC, 4, number of requesters (2..8).
- DWELL, 50000000, cycles a grant is held before rotation (>=2).
- CW, $clog2(DWELL), dwell counter width (derived, not overridden).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req  input  N_SRC  per-source display request, level, held while source wants the display
- data_in  input  16*N_SRC  flattened source values, source i at [16*i+15:16*i]
- hold  input  1  freezes the dwell counter (current grant kept while its req stays high)
- gnt  output  N_SRC  one-hot grant, registered
- data_out  output  16  value to hex display, registered
- src_idx  output  $clog2(N_SRC)  index of granted source
- dp  output  4  decimal-point mask = one-hot of src_idx[1:0], 0 when idle
- valid  output  1  high while any grant is active

Behaviour:
- Clock and reset: one clock domain; rst_n is asynchronous and active-low.
- Reset values: gnt=0, data_out=0, src_idx=0, dp=0, valid=0, cnt=0, state=IDLE, rr_ptr=N_SRC-1 so the first search starts at source 0.
- States: IDLE, SHOW.
- IDLE:
  - Each cycle, search req starting at (rr_ptr+1) mod N_SRC, wrapping.
  - On the first set bit k: next edge gnt=1<<k, src_idx=k, rr_ptr=k, cnt=0, valid=1, state=SHOW.
  - Latency is 1 cycle from req sampled to gnt.
- SHOW:
  - data_out <= data_in slice of src_idx on every edge: live tracking with 1-cycle latency. The first data_out update occurs on the same edge gnt rises.
  - cnt increments each cycle unless hold=1.
  - Rotation event: cnt==DWELL-1 with hold=0. On that edge, search from (src_idx+1) mod N_SRC.
    - If a different source is active, grant it: gnt switches in one edge with no gap cycle and no overlap; cnt=0.
    - If only the current source is active, keep it with gnt high continuously; cnt=0.
  - Drop event: req[src_idx]=0 sampled, taking precedence over hold and the dwell count. On the next edge, search from src_idx+1.
    - If another source is found: switch to it, cnt=0.
    - If none: gnt=0, valid=0, dp=0, state=IDLE. data_out keeps its last value (no blanking).
- Simultaneous events: drop and rotation in the same cycle are handled as a drop.
- New requests: never pre-empt an unexpired grant; they are served only at rotation or drop.
- Fairness: with all N_SRC requesting, each source is served once per N_SRC*DWELL cycles in index order.
- Glitches: a req pulse shorter than one cycle between edges is never seen; a one-cycle req in IDLE yields exactly one grant, dropped on the following edge.
- Invariants:
  - gnt is always one-hot or zero.
  - valid == |gnt.
  - dp == (valid ? 4'b1<<src_idx[1:0] : 0).
- Reset mid-SHOW: all outputs return to reset values immediately, asynchronously. After rst_n deasserts, arbitration restarts from source 0.

Test Plan:
- Bench parameters: N_SRC=4, DWELL=4.
- Reset then req=4'b0100, data_in[47:32]=16'hBEEF -> gnt=4'b0100 one edge later, data_out=16'hBEEF, src_idx=2, dp=4'b0100, valid=1; gnt held continuously over 12 cycles.
- req=4'b1111, source data 16'h0000/16'h1111/16'h2222/16'h3333 -> grant sequence 0,1,2,3,0 with each gnt exactly 4 cycles, data_out following 0000,1111,2222,3333, never two gnt bits set.
- Source 1 granted and req[1] dropped at cnt=1 with req=4'b1001 -> next edge gnt=4'b1000. With req=0 instead -> gnt=0, valid=0, dp=0, data_out stays 16'h1111.
- hold=1 for 10 cycles while source 0 is granted with req=4'b0011 -> gnt stays 4'b0001 for 10+4 cycles total. Dropping req[0] during hold -> switch to source 1 next edge.
- Change data_in[15:0] from 16'h1234 to 16'hABCD during source 0's grant -> data_out becomes 16'hABCD one edge later, with no grant change.
- Assert rst_n=0 mid-SHOW (source 3 granted) -> outputs zero without a clock edge. On release with req=4'b1000 -> gnt=4'b1000 after one edge.

Source files
------------

// File: rtl/display_arbiter.sv
// display_arbiter: round-robin time-slicing of N_SRC 16-bit sources onto one hex display, tagged on dp
module display_arbiter #(
  parameter int N_SRC = 4,
  parameter int DWELL = 50000000,
  localparam int CW = $clog2(DWELL),
  localparam int IW = $clog2(N_SRC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_SRC-1:0]      req,
  input  logic [16*N_SRC-1:0]   data_in,
  input  logic                  hold,
  output logic [N_SRC-1:0]      gnt,
  output logic [15:0]           data_out,
  output logic [IW-1:0]         src_idx,
  output logic [3:0]            dp,
  output logic                  valid
);
  typedef enum logic {IDLE, SHOW} state_t;
  state_t            state_q;
  logic [IW-1:0]     rr_ptr_q, src_idx_q, base, pick, j;
  logic [CW-1:0]     cnt_q;
  logic [N_SRC-1:0]  gnt_q;
  logic [15:0]       data_out_q;
  logic [3:0]        dp_q;
  logic              valid_q, hit, drop, rot, go, stop;
  logic [1:0]        pick2;
  always_comb begin
    base = state_q == IDLE ? rr_ptr_q : src_idx_q;
    hit = 1'b0;
    pick = '0;
    j = '0;
    for (int i = N_SRC; i >= 1; i--) begin
      j = IW'((int'(base) + i) % N_SRC);
      if (req[j]) begin
        hit = 1'b1;
        pick = j;
      end
    end
    pick2 = 2'(pick);
    drop = !req[src_idx_q];
    rot = !hold && cnt_q == CW'(DWELL - 1);
    go = state_q == IDLE ? hit : (drop || rot) && hit;
    stop = state_q == SHOW && drop && !hit;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= IW'(N_SRC - 1);
      src_idx_q  <= '0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      data_out_q <= '0;
      dp_q       <= '0;
      valid_q    <= 1'b0;
    end else if (go) begin
      state_q    <= SHOW;
      rr_ptr_q   <= pick;
      src_idx_q  <= pick;
      cnt_q      <= '0;
      gnt_q      <= N_SRC'(1) << pick;
      data_out_q <= data_in[16*pick +: 16];
      dp_q       <= 4'b1 << pick2;
      valid_q    <= 1'b1;
    end else if (stop) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      dp_q       <= '0;
      valid_q    <= 1'b0;
    end else if (state_q == SHOW) begin
      cnt_q      <= cnt_q + CW'(!hold);
      data_out_q <= data_in[16*src_idx_q +: 16];
    end
  end
  assign gnt      = gnt_q;
  assign data_out = data_out_q;
  assign src_idx  = src_idx_q;
  assign dp       = dp_q;
  assign valid    = valid_q;
endmodule

// File: tb/tb_display_arbiter.sv
// tb_display_arbiter: directed table-driven check of display_arbiter with N_SRC=4, DWELL=4
module tb_display_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [63:0] data_in = '0;
  logic        hold = 1'b0;
  logic [3:0]  gnt;
  logic [15:0] data_out;
  logic [1:0]  src_idx;
  logic [3:0]  dp;
  logic        valid;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [3:0]  req;
    logic        hold;
    logic [3:0]  eg;
    logic [15:0] ed;
  } vec_t;
  vec_t rr[17];
  display_arbiter #(.N_SRC(4), .DWELL(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in), .hold(hold),
    .gnt(gnt), .data_out(data_out), .src_idx(src_idx), .dp(dp), .valid(valid)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  task automatic ck(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask
  task automatic chk(input string nm, input logic [3:0] eg, input logic [15:0] ed);
    logic [1:0] ei;
    ei = 2'd0;
    for (int i = 0; i < 4; i++) if (eg[i]) ei = 2'(i);
    ck({nm, ".gnt"}, 32'(gnt), 32'(eg));
    ck({nm, ".data"}, 32'(data_out), 32'(ed));
    ck({nm, ".valid"}, 32'(valid), 32'(eg != 4'd0));
    ck({nm, ".dp"}, 32'(dp), 32'(eg));
    if (eg != 4'd0) ck({nm, ".idx"}, 32'(src_idx), 32'(ei));
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input logic [63:0] d);
    @(negedge clk);
    rst_n = 1'b0;
    req = '0;
    hold = 1'b0;
    data_in = d;
    #2;
    chk("reset", 4'b0000, 16'h0000);
    ck("reset.idx", 32'(src_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    rr[0]  = '{4'hf, 1'b0, 4'b0001, 16'h0000};
    rr[1]  = '{4'hf, 1'b0, 4'b0001, 16'h0000};
    rr[2]  = '{4'hf, 1'b0, 4'b0001, 16'h0000};
    rr[3]  = '{4'hf, 1'b0, 4'b0001, 16'h0000};
    rr[4]  = '{4'hf, 1'b0, 4'b0010, 16'h1111};
    rr[5]  = '{4'hf, 1'b0, 4'b0010, 16'h1111};
    rr[6]  = '{4'hf, 1'b0, 4'b0010, 16'h1111};
    rr[7]  = '{4'hf, 1'b0, 4'b0010, 16'h1111};
    rr[8]  = '{4'hf, 1'b0, 4'b0100, 16'h2222};
    rr[9]  = '{4'hf, 1'b0, 4'b0100, 16'h2222};
    rr[10] = '{4'hf, 1'b0, 4'b0100, 16'h2222};
    rr[11] = '{4'hf, 1'b0, 4'b0100, 16'h2222};
    rr[12] = '{4'hf, 1'b0, 4'b1000, 16'h3333};
    rr[13] = '{4'hf, 1'b0, 4'b1000, 16'h3333};
    rr[14] = '{4'hf, 1'b0, 4'b1000, 16'h3333};
    rr[15] = '{4'hf, 1'b0, 4'b1000, 16'h3333};
    rr[16] = '{4'hf, 1'b0, 4'b0001, 16'h0000};
    do_reset({16'h3333, 16'h2222, 16'h1111, 16'h0000});
    for (int i = 0; i < 17; i++) begin
      req = rr[i].req;
      hold = rr[i].hold;
      cyc();
      chk($sformatf("rr%0d", i), rr[i].eg, rr[i].ed);
    end
    do_reset({16'h0000, 16'hBEEF, 16'h0000, 16'h0000});
    req = 4'b0100;
    for (int i = 0; i < 13; i++) begin
      cyc();
      chk($sformatf("single%0d", i), 4'b0100, 16'hBEEF);
    end
    do_reset({16'h3333, 16'h2222, 16'h1111, 16'h0000});
    req = 4'b0010;
    cyc();
    chk("drop_a.g", 4'b0010, 16'h1111);
    cyc();
    req = 4'b1001;
    cyc();
    chk("drop_a.sw", 4'b1000, 16'h3333);
    do_reset({16'h3333, 16'h2222, 16'h1111, 16'h0000});
    req = 4'b0010;
    cyc();
    cyc();
    req = 4'b0000;
    cyc();
    chk("drop_b.idle", 4'b0000, 16'h1111);
    do_reset({16'h3333, 16'h2222, 16'h1111, 16'h5555});
    req = 4'b0011;
    cyc();
    chk("hold.g", 4'b0001, 16'h5555);
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk($sformatf("hold%0d", i), 4'b0001, 16'h5555);
    end
    hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("hold_run%0d", i), 4'b0001, 16'h5555);
    end
    cyc();
    chk("hold.rot", 4'b0010, 16'h1111);
    do_reset({16'h3333, 16'h2222, 16'h1111, 16'h5555});
    req = 4'b0011;
    cyc();
    hold = 1'b1;
    cyc();
    chk("hdrop.keep", 4'b0001, 16'h5555);
    req = 4'b0010;
    cyc();
    chk("hdrop.sw", 4'b0010, 16'h1111);
    do_reset({16'h3333, 16'h2222, 16'h1111, 16'h1234});
    req = 4'b0001;
    cyc();
    chk("live.a", 4'b0001, 16'h1234);
    cyc();
    data_in[15:0] = 16'hABCD;
    chk("live.b", 4'b0001, 16'h1234);
    cyc();
    chk("live.c", 4'b0001, 16'hABCD);
    do_reset({16'h3333, 16'h2222, 16'h1111, 16'h0000});
    req = 4'b0100;
    cyc();
    chk("pulse.g", 4'b0100, 16'h2222);
    req = 4'b0000;
    cyc();
    chk("pulse.d", 4'b0000, 16'h2222);
    do_reset({16'h3333, 16'h2222, 16'h1111, 16'h0000});
    req = 4'b1000;
    cyc();
    chk("mid.g", 4'b1000, 16'h3333);
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid.async", 4'b0000, 16'h0000);
    ck("mid.idx", 32'(src_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("mid.regrant", 4'b1000, 16'h3333);
    do_reset({16'h3333, 16'h2222, 16'h1111, 16'h0000});
    req = 4'b1001;
    cyc();
    chk("restart0", 4'b0001, 16'h0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
